// File: rtl/fft_frame_sequencer_if.sv
// Sample-memory ownership and framing bus between the frame sequencer and the
// AXI-stream buffers / FFT core. The master modport is the sequencer side.
interface fft_frame_sequencer_if #(
  parameter int MEM_ADDR_WDT = 12
);
  logic                    cfg_en;
  logic                    ld_word_vld;
  logic                    ld_tlast;
  logic                    ld_grant;
  logic [MEM_ADDR_WDT-1:0] ld_wr_addr;
  logic                    fft_start;
  logic                    fft_done;
  logic                    ul_grant;
  logic [MEM_ADDR_WDT-1:0] ul_rd_addr;
  logic                    ul_word_rdy;
  logic                    ul_last;
  logic [1:0]              mem_owner;
  logic [15:0]             frame_cnt;
  logic                    err_tlast;
  logic                    err_timeout;
  logic                    err_clr;

  modport master (
    input  cfg_en, ld_word_vld, ld_tlast, fft_done, ul_word_rdy, err_clr,
    output ld_grant, ld_wr_addr, fft_start, ul_grant, ul_rd_addr, ul_last,
           mem_owner, frame_cnt, err_tlast, err_timeout
  );

  modport slave (
    output cfg_en, ld_word_vld, ld_tlast, fft_done, ul_word_rdy, err_clr,
    input  ld_grant, ld_wr_addr, fft_start, ul_grant, ul_rd_addr, ul_last,
           mem_owner, frame_cnt, err_tlast, err_timeout
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller: LOAD -> COMPUTE -> UNLOAD ownership of the FFT sample memory.
// Optional COMPUTE watchdog and ERR state enabled by defining FFT_SEQ_TIMEOUT_EN.
module fft_frame_sequencer #(
  parameter int MEM_ADDR_WDT = 12,
  parameter int MEM_DEPTH    = 4096,
  parameter int UL_BASE_ADDR = 0,
  parameter int TIMEOUT_CYC  = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_frame_sequencer_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] COMPUTE = 3'd2;
  localparam logic [2:0] UNLOAD  = 3'd3;
`ifdef FFT_SEQ_TIMEOUT_EN
  localparam logic [2:0] ERR     = 3'd4;
`endif

  localparam logic [MEM_ADDR_WDT-1:0] ADDR_ONE     = MEM_ADDR_WDT'(1);
  localparam logic [MEM_ADDR_WDT-1:0] LD_LAST_ADDR = MEM_ADDR_WDT'(MEM_DEPTH - 1);
  localparam logic [MEM_ADDR_WDT-1:0] UL_BASE      = MEM_ADDR_WDT'(UL_BASE_ADDR);
  localparam logic [MEM_ADDR_WDT-1:0] UL_LAST_ADDR = MEM_ADDR_WDT'(UL_BASE_ADDR + MEM_DEPTH - 1);

  logic [2:0]              state_reg, state_next;
  logic [MEM_ADDR_WDT-1:0] ld_addr_reg, ld_addr_next;
  logic [MEM_ADDR_WDT-1:0] ul_addr_reg, ul_addr_next;
  logic [15:0]             frame_cnt_reg, frame_cnt_next;
  logic                    start_reg, start_next;
  logic                    err_tlast_reg, err_tlast_next;
  logic                    set_tlast_err;
  logic                    at_ul_last;

`ifdef FFT_SEQ_TIMEOUT_EN
  localparam int TO_WDT = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_WDT-1:0] TO_LAST = TO_WDT'(TIMEOUT_CYC - 1);

  logic [TO_WDT-1:0] to_cnt_reg, to_cnt_next;
  logic              err_to_reg, err_to_next;
  logic              set_to_err;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

  assign at_ul_last = (ul_addr_reg == UL_LAST_ADDR);

  always_comb begin
    state_next     = state_reg;
    ld_addr_next   = ld_addr_reg;
    ul_addr_next   = ul_addr_reg;
    frame_cnt_next = frame_cnt_reg;
    start_next     = 1'b0;
    set_tlast_err  = 1'b0;
`ifdef FFT_SEQ_TIMEOUT_EN
    set_to_err     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.cfg_en) begin
          state_next   = LOAD;
          ld_addr_next = '0;
        end
      end
      LOAD: begin
        if (bus.ld_word_vld) begin
          if (ld_addr_reg == LD_LAST_ADDR) begin
            // Missing TLAST on the final word is flagged but the frame still runs.
            state_next    = COMPUTE;
            start_next    = 1'b1;
            ld_addr_next  = '0;
            set_tlast_err = !bus.ld_tlast;
          end else if (bus.ld_tlast) begin
            // Short frame: drop it and restart filling from address 0.
            ld_addr_next  = '0;
            set_tlast_err = 1'b1;
          end else begin
            ld_addr_next  = ld_addr_reg + ADDR_ONE;
          end
        end
      end
      COMPUTE: begin
        if (bus.fft_done) begin
          state_next   = UNLOAD;
          ul_addr_next = UL_BASE;
        end
`ifdef FFT_SEQ_TIMEOUT_EN
        else if (to_cnt_reg == TO_LAST) begin
          state_next = ERR;
          set_to_err = 1'b1;
        end
`endif
      end
      UNLOAD: begin
        if (bus.ul_word_rdy) begin
          ul_addr_next = ul_addr_reg + ADDR_ONE;
          if (at_ul_last) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
            ld_addr_next   = '0;
            state_next     = bus.cfg_en ? LOAD : IDLE;
          end
        end
      end
`ifdef FFT_SEQ_TIMEOUT_EN
      ERR: begin
        if (bus.err_clr) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // A clear in the same cycle as a new error wins.
  assign err_tlast_next = bus.err_clr ? 1'b0 : (set_tlast_err | err_tlast_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ld_addr_reg   <= '0;
      ul_addr_reg   <= UL_BASE;
      frame_cnt_reg <= '0;
      start_reg     <= 1'b0;
      err_tlast_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ld_addr_reg   <= ld_addr_next;
      ul_addr_reg   <= ul_addr_next;
      frame_cnt_reg <= frame_cnt_next;
      start_reg     <= start_next;
      err_tlast_reg <= err_tlast_next;
    end
  end

`ifdef FFT_SEQ_TIMEOUT_EN
  // Counter is zero on COMPUTE entry and counts every COMPUTE cycle.
  assign to_cnt_next = (state_reg == COMPUTE) ? to_cnt_reg + TO_WDT'(1) : '0;
  assign err_to_next = bus.err_clr ? 1'b0 : (set_to_err | err_to_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg <= '0;
      err_to_reg <= 1'b0;
    end else begin
      to_cnt_reg <= to_cnt_next;
      err_to_reg <= err_to_next;
    end
  end

  assign bus.err_timeout = err_to_reg;
`else
  assign bus.err_timeout = 1'b0;
`endif

  always_comb begin
    case (state_reg)
      LOAD:    bus.mem_owner = 2'b01;
      COMPUTE: bus.mem_owner = 2'b10;
      UNLOAD:  bus.mem_owner = 2'b11;
      default: bus.mem_owner = 2'b00;
    endcase
  end

  assign bus.ld_grant   = (state_reg == LOAD);
  assign bus.ul_grant   = (state_reg == UNLOAD);
  assign bus.ul_last    = (state_reg == UNLOAD) && at_ul_last;
  assign bus.ld_wr_addr = ld_addr_reg;
  assign bus.ul_rd_addr = ul_addr_reg;
  assign bus.fft_start  = start_reg;
  assign bus.frame_cnt  = frame_cnt_reg;
  assign bus.err_tlast  = err_tlast_reg;

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Top-level frame controller for the FFT datapath. It sequences each 4096-point frame through three phases: LOAD, COMPUTE and UNLOAD. In each phase it grants the single FFT sample memory to exactly one owner: the AXI-stream slave interface buffer, the FFT core, or the AXI-stream master interface buffer. It generates the memory addresses for load and unload, pulses the core start, checks frame framing against TLAST, and counts completed frames.

## Interface
- MEM_ADDR_WDT, 12, memory address width (log2 FFT size)
- MEM_DEPTH, 4096, 64-bit words per frame; equals 2**MEM_ADDR_WDT
- UL_BASE_ADDR, 0, first unload address (output memory offset)
- TIMEOUT_CYC, 65536, COMPUTE watchdog limit in cycles
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cfg_en  in  1  run enable; level-sensitive
- ld_word_vld  in  1  slave IF buffer commits one 64-bit word to memory this cycle
- ld_tlast  in  1  TLAST of the beat that completed the committed word; qualified by ld_word_vld
- ld_grant  out  1  slave IF owns memory
- ld_wr_addr  out  MEM_ADDR_WDT  write address for the current load word
- fft_start  out  1  one-cycle start pulse to FFT core
- fft_done  in  1  one-cycle completion pulse from FFT core
- ul_grant  out  1  master IF owns memory
- ul_rd_addr  out  MEM_ADDR_WDT  read address for the current unload word
- ul_word_rdy  in  1  master IF buffer accepted the word at ul_rd_addr
- ul_last  out  1  current unload word is the final word of the frame
- mem_owner  out  2  00 none, 01 load, 10 FFT, 11 unload
- frame_cnt  out  16  completed frames, wraps at 2**16
- err_tlast  out  1  sticky framing error
- err_timeout  out  1  sticky watchdog error (FFT_SEQ_TIMEOUT_EN only)
- err_clr  in  1  clears both sticky errors

## Operation
- FSM states: IDLE, LOAD, COMPUTE, UNLOAD; ERR exists only with the macro.
- IDLE: cfg_en=1 moves to LOAD, and ld_wr_addr is set to 0.
- LOAD: ld_grant=1 and mem_owner=01. Each ld_word_vld increments ld_wr_addr.
  - ld_word_vld at ld_wr_addr=MEM_DEPTH-1 moves to COMPUTE.
  - If ld_tlast=0 on that word, err_tlast is set and the frame still proceeds.
  - ld_word_vld with ld_tlast=1 at ld_wr_addr<MEM_DEPTH-1 is a short frame: set err_tlast, reset ld_wr_addr to 0, stay in LOAD. The frame is dropped.
- COMPUTE: mem_owner=10. fft_start=1 in the first COMPUTE cycle only. fft_done moves to UNLOAD and sets ul_rd_addr=UL_BASE_ADDR. fft_done is accepted even in the same cycle as fft_start.
- UNLOAD: ul_grant=1 and mem_owner=11. Each ul_word_rdy increments ul_rd_addr.
  - ul_last=1 when ul_rd_addr=UL_BASE_ADDR+MEM_DEPTH-1.
  - ul_word_rdy with ul_last=1 increments frame_cnt and moves to LOAD if cfg_en=1, otherwise to IDLE.
- cfg_en=0 mid-frame never aborts; the current frame completes and the FSM then parks in IDLE.
- Inputs ignored outside their phase: ld_word_vld/ld_tlast outside LOAD, fft_done outside COMPUTE, ul_word_rdy outside UNLOAD.
- Addresses are MEM_ADDR_WDT-bit unsigned and wrap modulo MEM_DEPTH.
- err_clr takes priority over a set in the same cycle: the error is cleared.
- At most one grant is high at any time.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational input-to-output paths.
- A transition condition in cycle N means the new state's grants, owner and addresses are visible in cycle N+1.
- The memory write at ld_wr_addr occurs in the ld_word_vld cycle. The new address is valid the next cycle.
- Unload read latency belongs to the master IF. ul_rd_addr holds until ul_word_rdy.
- Minimum frame time is MEM_DEPTH + 1 + FFT latency + MEM_DEPTH cycles.
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - all grants, fft_start, ul_last, errors and mem_owner to 0;
  - ld_wr_addr to 0 and ul_rd_addr to UL_BASE_ADDR;
  - frame_cnt to 0.
- Reset mid-frame discards the frame.

## Configuration
- FFT_SEQ_TIMEOUT_EN defined: a cycle counter runs in COMPUTE starting from 0 at entry.
  - Reaching TIMEOUT_CYC-1 without fft_done moves to ERR and sets err_timeout.
  - In ERR all grants are 0 and mem_owner=00.
  - err_clr moves ERR to IDLE. An fft_done in ERR is ignored.
- FFT_SEQ_TIMEOUT_EN undefined: there is no counter and no ERR state. err_timeout is tied 0, TIMEOUT_CYC is unused, and COMPUTE waits indefinitely.

## Test plan
- Full frame: cfg_en=1, 4096 ld_word_vld with ld_tlast on word 4095, fft_done 10 cycles after fft_start, ul_word_rdy every cycle -> ld_wr_addr runs 0..4095, one fft_start pulse, ul_last only at address 4095, frame_cnt=1, no errors.
- Short frame: ld_tlast on word 99 -> err_tlast=1, ld_wr_addr returns to 0, no fft_start. The next 4096-word frame completes normally.
- Missing TLAST on word 4095 -> err_tlast=1 and COMPUTE is still entered. err_clr -> err_tlast=0 the next cycle.
- cfg_en dropped during COMPUTE -> UNLOAD completes, frame_cnt increments, FSM goes to IDLE, no further ld_grant.
- Backpressure: ul_word_rdy asserted 1 cycle in 3 -> ul_rd_addr holds between accepts, mem_owner stays 11, exactly 4096 accepts per frame.
- With FFT_SEQ_TIMEOUT_EN and TIMEOUT_CYC=64, withhold fft_done -> err_timeout=1 after 64 COMPUTE cycles, mem_owner=00. err_clr -> IDLE. Assert rst mid-LOAD -> all outputs return to their reset values immediately.
